peridot_pfc_bank: RTL and testbench

- One 8-pin bank of the PERIDOT pin function controller.
- Sits directly downstream of the PFC Avalon-MM interface stage:
  - decodes the 37-bit pfc_cmd bus (write strobe, 4-bit address, 32-bit writedata);
  - holds this bank's GPIO, pin-function and function-pin registers;
  - drives the read-response bus that the interface stage registers.
- Also muxes up to 8 peripheral function signals onto physical pins, and routes pins back to the function inputs.
- Four instances (BANK_ID 0..3) cover D0-D27. Their resp outputs are OR-combined.

---
 rtl/peridot_pfc_pkg.sv | 33 +++
 rtl/peridot_pfc_bank_if.sv | 13 +
 rtl/peridot_pfc_sync2.sv | 23 ++
 rtl/peridot_pfc_bank.sv | 127 ++++++++++++
 tb/tb_peridot_pfc_bank.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/peridot_pfc_pkg.sv
// Shared constants for the PERIDOT pin function controller banks:
// command bus layout, register offsets, pin/function codes and reset values.
package peridot_pfc_pkg;

  localparam int CMD_WR_BIT   = 36;
  localparam int CMD_ADDR_MSB = 35;
  localparam int CMD_ADDR_LSB = 32;

  localparam logic [1:0] REG_DIN     = 2'd0;
  localparam logic [1:0] REG_DOUT    = 2'd1;
  localparam logic [1:0] REG_PINFUNC = 2'd2;
  localparam logic [1:0] REG_FUNCPIN = 2'd3;

  localparam logic [3:0] PINFUNC_HIZ       = 4'h0;
  localparam logic [3:0] PINFUNC_GPIO      = 4'h1;
  localparam logic [3:0] PINFUNC_FUNC_BASE = 4'h8;
  localparam logic [3:0] FUNCPIN_ZERO      = 4'h8;

  localparam logic [7:0]  DOUT_RESET    = 8'h00;
  localparam logic [31:0] PINFUNC_RESET = 32'h0000_0000;
  localparam logic [31:0] FUNCPIN_RESET = 32'h8888_8888;

  // One bit per physical pin that actually exists in a bank of the given width.
  function automatic logic [7:0] pin_mask(input int width);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      m[i] = (i < width);
    end
    return m;
  endfunction

endpackage

// File: rtl/peridot_pfc_bank_if.sv
// Command/response bus between the PFC Avalon-MM interface stage and a bank.
// The command is valid every cycle; there is no ready: a bank accepts a write on
// every edge where the strobe is high and it is selected, and resp is always valid.
interface peridot_pfc_bank_if;
  import peridot_pfc_pkg::*;

  logic [36:0] coe_pfc_cmd;
  logic [31:0] coe_pfc_resp;

  modport master (output coe_pfc_cmd, input coe_pfc_resp);
  modport slave  (input coe_pfc_cmd, output coe_pfc_resp);

endinterface

// File: rtl/peridot_pfc_sync2.sv
// Generic N-bit two-flop synchronizer with synchronous, active-high reset.
module peridot_pfc_sync2 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/peridot_pfc_bank.sv
// One 8-pin PFC bank: GPIO/pinfunc/funcpin registers, read-response mux,
// pin output mux (registered) and function input routing (combinational).
module peridot_pfc_bank
  import peridot_pfc_pkg::*;
#(
  parameter int BANK_ID   = 0,
  parameter int PIN_WIDTH = 8
) (
  input  logic                 csi_clk,
  input  logic                 rsi_reset,
  peridot_pfc_bank_if.slave    pfc,
  input  logic [7:0]           coe_pin_in,
  output logic [7:0]           coe_pin_out,
  output logic [7:0]           coe_pin_oe,
  input  logic [7:0]           coe_func_out,
  input  logic [7:0]           coe_func_oe,
  output logic [7:0]           coe_func_in
);

  localparam logic [1:0] BANK_SEL = 2'(BANK_ID);
  localparam logic [7:0] PIN_MASK = pin_mask(PIN_WIDTH);

  logic        sel;
  logic        wr;
  logic [1:0]  offset;
  logic [31:0] wdata;

  logic [7:0]  dout_q;
  logic [31:0] pinfunc_q;
  logic [31:0] funcpin_q;

  logic [7:0]  din_sync;
  logic [7:0]  din;
  logic [7:0]  pin_raw;
  logic [7:0]  pin_out_nxt;
  logic [7:0]  pin_oe_nxt;
  logic [31:0] resp;

  assign sel    = (pfc.coe_pfc_cmd[CMD_ADDR_MSB -: 2] == BANK_SEL);
  assign offset = pfc.coe_pfc_cmd[CMD_ADDR_LSB +: 2];
  assign wdata  = pfc.coe_pfc_cmd[31:0];
  assign wr     = pfc.coe_pfc_cmd[CMD_WR_BIT] & sel;

  // wdata[15:8] protects the matching dout bit from this write.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      dout_q    <= DOUT_RESET;
      pinfunc_q <= PINFUNC_RESET;
      funcpin_q <= FUNCPIN_RESET;
    end else if (wr) begin
      case (offset)
        REG_DOUT:    dout_q    <= (dout_q & wdata[15:8]) | (wdata[7:0] & ~wdata[15:8]);
        REG_PINFUNC: pinfunc_q <= wdata;
        REG_FUNCPIN: funcpin_q <= wdata;
        default:     ;
      endcase
    end
  end

  peridot_pfc_sync2 #(.N(8)) u_din_sync (
    .clk (csi_clk),
    .rst (rsi_reset),
    .d   (coe_pin_in),
    .q   (din_sync)
  );

  assign din     = din_sync & PIN_MASK;
  assign pin_raw = coe_pin_in & PIN_MASK;

  always_comb begin
    logic [3:0] code;
    code        = PINFUNC_HIZ;
    pin_out_nxt = '0;
    pin_oe_nxt  = '0;
    for (int n = 0; n < 8; n++) begin
      code = pinfunc_q[4*n +: 4];
      if (PIN_MASK[n]) begin
        if (code >= PINFUNC_FUNC_BASE) begin
          pin_out_nxt[n] = coe_func_out[code[2:0]];
          pin_oe_nxt[n]  = coe_func_oe[code[2:0]];
        end else if (code == PINFUNC_GPIO) begin
          pin_out_nxt[n] = dout_q[n];
          pin_oe_nxt[n]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      coe_pin_out <= '0;
      coe_pin_oe  <= '0;
    end else begin
      coe_pin_out <= pin_out_nxt;
      coe_pin_oe  <= pin_oe_nxt;
    end
  end

  // Raw, unsynchronized pins: the receiving peripheral owns synchronization.
  always_comb begin
    logic [3:0] fcode;
    fcode       = FUNCPIN_ZERO;
    coe_func_in = '0;
    for (int f = 0; f < 8; f++) begin
      fcode = funcpin_q[4*f +: 4];
      if (fcode < FUNCPIN_ZERO) begin
        coe_func_in[f] = pin_raw[fcode[2:0]];
      end
    end
  end

  always_comb begin
    resp = '0;
    if (sel) begin
      case (offset)
        REG_DIN:     resp = {24'h0, din};
        REG_DOUT:    resp = {24'h0, dout_q};
        REG_PINFUNC: resp = pinfunc_q;
        REG_FUNCPIN: resp = funcpin_q;
        default:     resp = '0;
      endcase
    end
  end

  assign pfc.coe_pfc_resp = resp;

endmodule

// File: tb/tb_peridot_pfc_bank.sv
// Bench for peridot_pfc_bank: bank 0 (8 pins) and bank 2 (6 pins) share one
// command stream; each vector is one clock, sampled #1 after the rising edge.
module tb_peridot_pfc_bank;

  typedef struct {
    string       name;
    logic        rst;
    logic [36:0] cmd;
    logic [7:0]  pin_in;
    logic [7:0]  func_out;
    logic [7:0]  func_oe;
    logic        dut;
    logic [3:0]  chk;
    logic [31:0] resp;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic [7:0]  func_in;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [36:0] cmd;
  logic [7:0]  pin_in;
  logic [7:0]  func_out;
  logic [7:0]  func_oe;

  logic [7:0] pin_out0, pin_oe0, func_in0;
  logic [7:0] pin_out2, pin_oe2, func_in2;

  logic [31:0] exp_q[$];
  vec_t        vecs[$];
  int          tests;
  int          failed;

  peridot_pfc_bank_if bus0 ();
  peridot_pfc_bank_if bus2 ();

  assign bus0.coe_pfc_cmd = cmd;
  assign bus2.coe_pfc_cmd = cmd;

  peridot_pfc_bank #(.BANK_ID(0), .PIN_WIDTH(8)) dut0 (
    .csi_clk      (clk),
    .rsi_reset    (rst),
    .pfc          (bus0),
    .coe_pin_in   (pin_in),
    .coe_pin_out  (pin_out0),
    .coe_pin_oe   (pin_oe0),
    .coe_func_out (func_out),
    .coe_func_oe  (func_oe),
    .coe_func_in  (func_in0)
  );

  peridot_pfc_bank #(.BANK_ID(2), .PIN_WIDTH(6)) dut2 (
    .csi_clk      (clk),
    .rsi_reset    (rst),
    .pfc          (bus2),
    .coe_pin_in   (pin_in),
    .coe_pin_out  (pin_out2),
    .coe_pin_oe   (pin_oe2),
    .coe_func_out (func_out),
    .coe_func_oe  (func_oe),
    .coe_func_in  (func_in2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] mkc(input logic wr, input logic [3:0] addr, input logic [31:0] data);
    return {wr, addr, data};
  endfunction

  function automatic vec_t mkv(input string name, input logic r, input logic [36:0] c,
                               input logic [7:0] pi, input logic [7:0] fo, input logic [7:0] foe,
                               input logic d, input logic [3:0] chk, input logic [31:0] resp,
                               input logic [7:0] po, input logic [7:0] poe, input logic [7:0] fi);
    vec_t v;
    v.name = name; v.rst = r; v.cmd = c; v.pin_in = pi; v.func_out = fo; v.func_oe = foe;
    v.dut = d; v.chk = chk; v.resp = resp; v.pin_out = po; v.pin_oe = poe; v.func_in = fi;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] got_resp;
    logic [31:0] exp_resp;
    logic [7:0]  got_out, got_oe, got_fin;
    @(negedge clk);
    rst      = v.rst;
    cmd      = v.cmd;
    pin_in   = v.pin_in;
    func_out = v.func_out;
    func_oe  = v.func_oe;
    exp_q.push_back(v.resp);
    @(posedge clk);
    #1;
    got_resp = v.dut ? bus2.coe_pfc_resp : bus0.coe_pfc_resp;
    got_out  = v.dut ? pin_out2 : pin_out0;
    got_oe   = v.dut ? pin_oe2  : pin_oe0;
    got_fin  = v.dut ? func_in2 : func_in0;
    exp_resp = exp_q.pop_front();
    if (v.chk[0]) check({v.name, ".resp"},    got_resp,       exp_resp);
    if (v.chk[1]) check({v.name, ".pin_out"}, {24'h0, got_out}, {24'h0, v.pin_out});
    if (v.chk[2]) check({v.name, ".pin_oe"},  {24'h0, got_oe},  {24'h0, v.pin_oe});
    if (v.chk[3]) check({v.name, ".func_in"}, {24'h0, got_fin}, {24'h0, v.func_in});
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst      = 1'b1;
    cmd      = '0;
    pin_in   = '0;
    func_out = '0;
    func_oe  = '0;

    // Bank 0, 8 pins: reset defaults, masked dout, GPIO, function routing, din/func_in.
    vecs.push_back(mkv("rst_din",       0, mkc(0, 4'h0, 0),            8'h00, 8'h00, 8'h00, 0, 4'hF, 32'h0,        8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("rst_dout",      0, mkc(0, 4'h1, 0),            8'h00, 8'h00, 8'h00, 0, 4'h1, 32'h0,        8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("rst_pinfunc",   0, mkc(0, 4'h2, 0),            8'h00, 8'h00, 8'h00, 0, 4'h1, 32'h0,        8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("rst_funcpin",   0, mkc(0, 4'h3, 0),            8'h00, 8'h00, 8'h00, 0, 4'h9, 32'h88888888, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("dout_a5",       0, mkc(1, 4'h1, 32'h00A5),     8'h00, 8'h00, 8'h00, 0, 4'h1, 32'hA5,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("dout_mask",     0, mkc(1, 4'h1, 32'hF00F),     8'h00, 8'h00, 8'h00, 0, 4'h1, 32'hAF,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("dout_03",       0, mkc(1, 4'h1, 32'h0003),     8'h00, 8'h00, 8'h00, 0, 4'h1, 32'h03,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("pf_gpio_wr",    0, mkc(1, 4'h2, 32'h11),       8'h00, 8'h00, 8'h00, 0, 4'h7, 32'h11,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("pf_gpio_pin",   0, mkc(0, 4'h2, 0),            8'h00, 8'h00, 8'h00, 0, 4'h7, 32'h11,       8'h03, 8'h03, 8'h00));
    vecs.push_back(mkv("pf_func_wr",    0, mkc(1, 4'h2, 32'hA011),     8'h00, 8'h04, 8'h04, 0, 4'h7, 32'hA011,     8'h03, 8'h03, 8'h00));
    vecs.push_back(mkv("pf_func_pin",   0, mkc(0, 4'h2, 0),            8'h00, 8'h04, 8'h04, 0, 4'h7, 32'hA011,     8'h0B, 8'h0B, 8'h00));
    vecs.push_back(mkv("func_out_1edge",0, mkc(0, 4'h2, 0),            8'h00, 8'h00, 8'h04, 0, 4'h6, 32'hA011,     8'h03, 8'h0B, 8'h00));
    vecs.push_back(mkv("fp_wr",         0, mkc(1, 4'h3, 32'h88688888), 8'h00, 8'h00, 8'h04, 0, 4'h9, 32'h88688888, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("fin_comb",      0, mkc(0, 4'h0, 0),            8'h40, 8'h00, 8'h04, 0, 4'h9, 32'h00,       8'h00, 8'h00, 8'h20));
    vecs.push_back(mkv("din_2edge",     0, mkc(0, 4'h0, 0),            8'h40, 8'h00, 8'h04, 0, 4'hF, 32'h40,       8'h03, 8'h0B, 8'h20));
    vecs.push_back(mkv("din_fall_1",    0, mkc(0, 4'h0, 0),            8'h00, 8'h00, 8'h04, 0, 4'h9, 32'h40,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("din_fall_2",    0, mkc(0, 4'h0, 0),            8'h00, 8'h00, 8'h04, 0, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("din_wr_ign",    0, mkc(1, 4'h0, 32'hFFFFFFFF), 8'h00, 8'h00, 8'h04, 0, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("other_bank_wr", 0, mkc(1, 4'h5, 32'hFF),       8'h00, 8'h00, 8'h04, 0, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("other_bank_chk",0, mkc(0, 4'h1, 0),            8'h00, 8'h00, 8'h04, 0, 4'h1, 32'h03,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("pf_reserved_wr",0, mkc(1, 4'h2, 32'h31),       8'h00, 8'h00, 8'h04, 0, 4'h1, 32'h31,       8'h00, 8'h00, 8'h00));
    vecs.push_back(mkv("pf_reserved",   0, mkc(0, 4'h2, 0),            8'h00, 8'h00, 8'h04, 0, 4'h7, 32'h31,       8'h01, 8'h01, 8'h00));

    repeat (3) @(posedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);

    // Bank 2, 6 pins: selection by address[3:2] and masking of pins 6/7.
    run_vec(mkv("b2_wr5_ign",  0, mkc(1, 4'h5, 32'hFF),       8'h00, 8'h00, 8'h00, 1, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_rd9",      0, mkc(0, 4'h9, 0),            8'h00, 8'h00, 8'h00, 1, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_rd4",      0, mkc(0, 4'h4, 0),            8'h00, 8'h00, 8'h00, 1, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_wr9",      0, mkc(1, 4'h9, 32'hFF),       8'h00, 8'h00, 8'h00, 1, 4'h1, 32'hFF,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_pf",       0, mkc(1, 4'hA, 32'h11111111), 8'h00, 8'h00, 8'h00, 1, 4'h1, 32'h11111111, 8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_pins",     0, mkc(0, 4'hA, 0),            8'hFF, 8'h00, 8'h00, 1, 4'h7, 32'h11111111, 8'h3F, 8'h3F, 8'h00));
    run_vec(mkv("b2_din_mask", 0, mkc(0, 4'h8, 0),            8'hFF, 8'h00, 8'h00, 1, 4'h1, 32'h3F,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("b2_fp_mask",  0, mkc(1, 4'hB, 32'h88888567), 8'hFF, 8'h00, 8'h00, 1, 4'h9, 32'h88888567, 8'h00, 8'h00, 8'h04));

    // Reset asserted alongside a write: reset wins, synchronizer restarts from 0.
    run_vec(mkv("rst_with_wr", 1, mkc(1, 4'h1, 32'h55),       8'hFF, 8'h00, 8'h00, 0, 4'hF, 32'h00,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("rst_din_1",   0, mkc(0, 4'h0, 0),            8'hFF, 8'h00, 8'h00, 0, 4'h1, 32'h00,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("rst_din_2",   0, mkc(0, 4'h0, 0),            8'hFF, 8'h00, 8'h00, 0, 4'h1, 32'hFF,       8'h00, 8'h00, 8'h00));
    run_vec(mkv("rst_fp_after",0, mkc(0, 4'h3, 0),            8'hFF, 8'h00, 8'h00, 0, 4'hF, 32'h88888888, 8'h00, 8'h00, 8'h00));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
